// File: rtl/lat_rf_pkg.sv
// lat_rf_pkg: shared types, reset-pattern helper and out-of-range read value for lat_rf_set
package lat_rf_pkg;
  localparam int WIDTH_MAX = 64;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 8;
  typedef logic [WIDTH_DEF-1:0] data_t;
  typedef logic [$clog2(DEPTH_DEF)-1:0] addr_t;
  localparam logic [WIDTH_MAX-1:0] RD_OOR_VAL = '0;
  function automatic logic [WIDTH_MAX-1:0] init_rep(input logic b);
    return {WIDTH_MAX{b}};
  endfunction
endpackage

// File: rtl/lat_rf_cg.sv
// lat_rf_cg: glitch-free latch clock gate for one register-file entry
//   CLK  in  clock; EN is captured while CLK=1
//   RSTB in  async active-low reset, forces GCLK low
//   EN   in  entry write enable
//   GCLK out gated clock, high during the low phase following an enabled edge
module lat_rf_cg (
  input  logic CLK,
  input  logic RSTB,
  input  logic EN,
  output logic GCLK
);
  logic en_l;
  always_latch begin
    if (!RSTB) en_l <= 1'b0;
    else if (CLK) en_l <= EN;
  end
  assign GCLK = en_l & ~CLK & RSTB;
endmodule

// File: rtl/lat_rf_set.sv
// lat_rf_set: DEPTH x WIDTH latch register file, one staged write port, NRD async read ports
//   CLK   in  clock, write request sampled on rising edge
//   RSTB  in  async active-low reset, presets every entry to INIT
//   WE/WADDR/WDATA in  write request
//   RADDR in  NRD packed read addresses
//   RDATA out NRD packed read data, zero for addresses >= DEPTH
//   Macro LAT_RF_SET_BYPASS_EN forwards staged write data to matching read ports.
module lat_rf_set import lat_rf_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int NRD = 2,
  parameter logic [WIDTH-1:0] INIT = WIDTH'(init_rep(1'b1)),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               CLK,
  input  logic               RSTB,
  input  logic               WE,
  input  logic [AW-1:0]      WADDR,
  input  logic [WIDTH-1:0]   WDATA,
  input  logic [NRD*AW-1:0]  RADDR,
  output logic [NRD*WIDTH-1:0] RDATA
);
  logic we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0] gclk;
  always_comb begin
    we_d = WE;
    waddr_d = WE ? WADDR : waddr_q;
    wdata_d = WE ? WDATA : wdata_q;
  end
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end
  // an out-of-range waddr_q matches no entry, so the write is dropped
  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    logic [WIDTH-1:0] q;
    lat_rf_cg u_cg (
      .CLK(CLK),
      .RSTB(RSTB),
      .EN(we_q && waddr_q == AW'(e)),
      .GCLK(gclk[e])
    );
    always_latch begin
      if (!RSTB) q <= INIT;
      else if (gclk[e]) q <= wdata_q;
    end
    assign mem[e] = q;
  end
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] ra;
    logic ok;
    assign ra = RADDR[p*AW +: AW];
    assign ok = {1'b0, ra} < (AW+1)'(DEPTH);
`ifdef LAT_RF_SET_BYPASS_EN
    assign RDATA[p*WIDTH +: WIDTH] = !ok ? RD_OOR_VAL[WIDTH-1:0] :
                                     (we_q && ra == waddr_q) ? wdata_q : mem[ra];
`else
    assign RDATA[p*WIDTH +: WIDTH] = ok ? mem[ra] : RD_OOR_VAL[WIDTH-1:0];
`endif
  end
endmodule
